hp_vpu_csr_arb: RTL
===================

Name: hp_vpu_csr_arb

Overview:
Round-robin arbiter that shares the single VPU CSR register port between NREQ requesters (requester 0 = scalar core, requester 1 = debug/bus bridge). It forwards one transaction per cycle to the CSR block. It tracks ownership of the fixed 1-cycle response and routes read data, read-valid, error and a synthesized write-ack back to the issuing requester. It also supports a per-requester bus lock for atomic read-modify-write sequences on control/W1C registers, with a lock watchdog.

Parameters:
NREQ, 2, number of upstream requesters (2..4)
LOCK_TIMEOUT, 16, idle cycles of the lock owner before a forced unlock (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_i  in  NREQ  per-requester request valid
lock_i  in  NREQ  requester wants to keep ownership after this transaction
we_i  in  NREQ  write enable per requester
addr_i  in  NREQx12  register address per requester
wdata_i  in  NREQx32  write data per requester
be_i  in  NREQx4  byte enables per requester
gnt_o  out  NREQ  grant (one-hot or zero), same cycle as request
rdata_o  out  32  read data, broadcast to all requesters
rvalid_o  out  NREQ  read data valid for the owning requester
wack_o  out  NREQ  write accepted, 1 cycle after write grant
error_o  out  NREQ  access error for the owning requester
m_req_o  out  1  downstream request
m_gnt_i  in  1  downstream grant
m_we_o  out  1  downstream write enable
m_addr_o  out  12  downstream address
m_wdata_o  out  32  downstream write data
m_be_o  out  4  downstream byte enables
m_rdata_i  in  32  downstream read data
m_rvalid_i  in  1  downstream read valid (1 cycle after grant, reads only)
m_error_i  in  1  downstream error (1 cycle after grant, reads and writes)
lock_timeout_o  out  1  1-cycle pulse on forced unlock
proto_err_o  out  1  sticky: response seen with no outstanding transaction; cleared only by reset

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, wack_o=0, error_o=0, m_req_o=0, lock_timeout_o=0, proto_err_o=0, rr_ptr=0, lock state UNLOCKED, rsp_vld_q=0.
- Arbitration (combinational):
  - UNLOCKED: the winner is the first asserted req_i scanning from rr_ptr upward, modulo NREQ.
  - LOCKED: only lock_owner is eligible; requests from all other requesters are held off (no grant).
- m_req_o = winner exists. m_* fields are muxed from the winner.
- gnt_o[winner] = m_gnt_i. Accept = m_req_o && m_gnt_i.
- On accept: rr_ptr <= (winner+1) mod NREQ; rsp_vld_q<=1, rsp_id_q<=winner, rsp_we_q<=we_i[winner]. Otherwise rsp_vld_q<=0.
- Back-to-back accepts every cycle are allowed. Response latency is exactly 1 cycle after accept.
- Response cycle, when rsp_vld_q=1:
  - rvalid_o[rsp_id_q] = m_rvalid_i && !rsp_we_q.
  - wack_o[rsp_id_q] = rsp_we_q.
  - error_o[rsp_id_q] = m_error_i.
  - All other bits are 0. rdata_o = m_rdata_i at all times.
- When rsp_vld_q=0 and (m_rvalid_i || m_error_i): set proto_err_o. Nothing is routed upstream.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED: on accept with lock_i[winner]=1; lock_owner<=winner, idle_cnt<=0.
  - LOCKED -> UNLOCKED: on an owner accept with lock_i[owner]=0. That transaction is still performed.
  - LOCKED -> LOCKED: on an owner accept with lock_i=1; idle_cnt<=0.
  - LOCKED idle: each cycle with req_i[owner]=0, idle_cnt increments (8-bit, saturating). When idle_cnt reaches LOCK_TIMEOUT-1 on an idle cycle, go to UNLOCKED, pulse lock_timeout_o and set rr_ptr<=(owner+1) mod NREQ.
  - Owner request present but m_gnt_i=0: idle_cnt is held, not incremented.
- The rr_ptr update while LOCKED is irrelevant. On unlock, rr_ptr = owner+1, so a waiting requester wins next.
- Simultaneous events:
  - Unlock-by-accept and timeout in the same cycle cannot occur, because an accept implies the owner is requesting.
  - A new accept in the response cycle of the previous one is legal; the response registers are simply overwritten.
- Asynchronous reset mid-transaction: the in-flight response is dropped, with no upstream pulse after reset release. Lock is released.
- Requesters must hold req/fields stable until granted. The block does not register requests, so it adds zero request latency.

Decomposition:
- Add to hp_vpu_pkg: CSR_ADDR_W=12, CSR_DATA_W=32, CSR_BE_W=4, and typedef csr_req_t (we, addr, wdata, be, lock) for packed upstream request bundles.
- One sub-module, hp_vpu_rr_pick: parameterized NREQ round-robin priority picker (req vector + pointer -> one-hot winner + index), reusable by other VPU arbiters.

Test Plan:
- Single read: req_i=01, addr 0x000, m_gnt_i=1 -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o=0x48500006, error_o=00.
- Contention: req_i=11 for 4 cycles, both reads -> grants alternate 01,10,01,10; each rvalid_o pulse goes to the matching requester 1 cycle later.
- Write plus invalid address: req1 writes 0x3FC -> wack_o=10 and error_o=10 in the following cycle, rvalid_o=00.
- Lock RMW: req0 read 0x080 with lock=1, req1 requesting throughout, then req0 writes 0x080 with lock=0 -> req1 not granted until the cycle after req0's write; req1 is granted next.
- Lock timeout (LOCK_TIMEOUT=16): req0 locks, then drops req, req1 pending -> lock_timeout_o pulses 16 cycles after the lock accept; req1 is granted in the next cycle.
- Protocol/reset: inject m_rvalid_i with nothing outstanding -> proto_err_o=1 and stays set. Assert rst_n low in a response cycle -> all outputs 0 and no pulse after release.

Source files
------------

// File: rtl/hp_vpu_pkg.sv
// Shared VPU types and widths for the CSR port and its arbiter.
package hp_vpu_pkg;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned CSR_DATA_W = 32;
    localparam int unsigned CSR_BE_W   = 4;
    localparam int unsigned LOCK_CNT_W = 8;

    typedef struct packed {
        logic                  we;
        logic [CSR_ADDR_W-1:0] addr;
        logic [CSR_DATA_W-1:0] wdata;
        logic [CSR_BE_W-1:0]   be;
        logic                  lock;
    } csr_req_t;

    typedef enum logic {
        StUnlocked,
        StLocked
    } lock_state_e;

endpackage

// File: rtl/hp_vpu_csr_arb_if.sv
// Single VPU CSR register port: request fields out, 1-cycle response back.
interface hp_vpu_csr_arb_if;
    import hp_vpu_pkg::*;

    logic                  req;
    logic                  gnt;
    logic                  we;
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] wdata;
    logic [CSR_BE_W-1:0]   be;
    logic [CSR_DATA_W-1:0] rdata;
    logic                  rvalid;
    logic                  error;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rdata, rvalid, error
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rdata, rvalid, error
    );

endinterface

// File: rtl/hp_vpu_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr_i, wrapping modulo NREQ.
module hp_vpu_rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        j        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = IDX_W'((32'(ptr_i) + i) % NREQ);
            if (!valid_o && req_i[j]) begin
                valid_o     = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = j;
            end
        end
    end

endmodule

// File: rtl/hp_vpu_csr_arb.sv
// Round-robin arbiter sharing the VPU CSR port between NREQ requesters, with
// response routing, per-requester bus lock and a lock watchdog.
module hp_vpu_csr_arb
    import hp_vpu_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NREQ-1:0]                      req_i,
    input  logic [NREQ-1:0]                      lock_i,
    input  logic [NREQ-1:0]                      we_i,
    input  logic [NREQ-1:0][CSR_ADDR_W-1:0]      addr_i,
    input  logic [NREQ-1:0][CSR_DATA_W-1:0]      wdata_i,
    input  logic [NREQ-1:0][CSR_BE_W-1:0]        be_i,
    output logic [NREQ-1:0]                      gnt_o,
    output logic [CSR_DATA_W-1:0]                rdata_o,
    output logic [NREQ-1:0]                      rvalid_o,
    output logic [NREQ-1:0]                      wack_o,
    output logic [NREQ-1:0]                      error_o,
    hp_vpu_csr_arb_if.master                     m,
    output logic                                 lock_timeout_o,
    output logic                                 proto_err_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    lock_state_e           state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [LOCK_CNT_W-1:0] idle_q, idle_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [IDX_W-1:0]      rsp_id_q, rsp_id_d;
    logic                  rsp_we_q, rsp_we_d;
    logic                  proto_q, proto_d;

    csr_req_t [NREQ-1:0]   up_req;
    logic [NREQ-1:0]       elig;
    logic [NREQ-1:0]       win_oh;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_vld;
    logic                  accept;
    logic                  owner_idle;
    logic                  timeout;

    function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            up_req[i] = '{we: we_i[i], addr: addr_i[i], wdata: wdata_i[i], be: be_i[i],
                          lock: lock_i[i]};
        end
    end

    // While locked only the owner may compete, so the picker always lands on it.
    always_comb begin
        elig = req_i;
        if (state_q == StLocked) begin
            elig          = '0;
            elig[owner_q] = req_i[owner_q];
        end
    end

    hp_vpu_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (elig),
        .ptr_i    (ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .valid_o  (win_vld)
    );

    assign accept     = win_vld && m.gnt;
    assign owner_idle = (state_q == StLocked) && !req_i[owner_q];
    assign timeout    = owner_idle && (idle_q == LOCK_CNT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StUnlocked;
            owner_q   <= '0;
            ptr_q     <= '0;
            idle_q    <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_we_q  <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            idle_q    <= idle_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_we_q  <= rsp_we_d;
            proto_q   <= proto_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        idle_d    = idle_q;
        ptr_d     = accept ? nxt_idx(win_idx) : ptr_q;
        rsp_vld_d = accept;
        rsp_id_d  = accept ? win_idx : rsp_id_q;
        rsp_we_d  = accept ? up_req[win_idx].we : rsp_we_q;
        proto_d   = proto_q | (!rsp_vld_q && (m.rvalid || m.error));
        unique case (state_q)
            StUnlocked: begin
                if (accept && up_req[win_idx].lock) begin
                    state_d = StLocked;
                    owner_d = win_idx;
                    idle_d  = '0;
                end
            end
            StLocked: begin
                if (accept) begin
                    if (up_req[win_idx].lock) idle_d = '0;
                    else                      state_d = StUnlocked;
                end else if (timeout) begin
                    // Hand the bus to whoever sits after the stalled owner.
                    state_d = StUnlocked;
                    ptr_d   = nxt_idx(owner_q);
                end else if (owner_idle && (idle_q != '1)) begin
                    idle_d = idle_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        gnt_o    = accept ? win_oh : '0;
        m.req    = win_vld;
        m.we     = up_req[win_idx].we;
        m.addr   = up_req[win_idx].addr;
        m.wdata  = up_req[win_idx].wdata;
        m.be     = up_req[win_idx].be;
        rdata_o  = m.rdata;
        rvalid_o = '0;
        wack_o   = '0;
        error_o  = '0;
        if (rsp_vld_q) begin
            rvalid_o[rsp_id_q] = m.rvalid && !rsp_we_q;
            wack_o[rsp_id_q]   = rsp_we_q;
            error_o[rsp_id_q]  = m.error;
        end
        lock_timeout_o = timeout;
        proto_err_o    = proto_q;
    end

endmodule
